// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stall/flush controller: stall vector
// layout, canned stall patterns, controller states and common widths.
package pipe_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int PC_W       = 32;

    // Bit positions inside the stall vector, front of the pipe first.
    localparam int STALL_PC     = 0;
    localparam int STALL_IF     = 1;
    localparam int STALL_ID     = 2;
    localparam int STALL_EX_BIT = 3;
    localparam int STALL_MEM    = 4;
    localparam int STALL_WB     = 5;

    typedef logic [STALL_WB:STALL_PC] stall_t;

    // Hold nothing / hold PC..ID (bubble into EX) / hold PC..EX (EX busy).
    localparam stall_t STALL_NONE = 6'b000000;
    localparam stall_t STALL_LU   = 6'b000111;
    localparam stall_t STALL_EX   = 6'b001111;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        EXWAIT = 2'd1,
        FLUSH  = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle of everything the pipeline exchanges with the stall/flush
// controller. The pipeline side is the master, the controller the slave.
interface pipe_ctrl_if
    import pipe_pkg::*;
#(
    parameter int CNT_W = 32
) ();

    logic                  id_reg1_read_en_i;
    logic [REG_ADDR_W-1:0] id_reg1_read_addr_i;
    logic                  id_reg2_read_en_i;
    logic [REG_ADDR_W-1:0] id_reg2_read_addr_i;
    logic                  ex_is_load_i;
    logic                  ex_write_reg_en_i;
    logic [REG_ADDR_W-1:0] ex_write_reg_addr_i;
    logic                  stallreq_ex_i;
    logic                  flush_req_i;
    logic [PC_W-1:0]       flush_pc_i;
    stall_t                stall_o;
    logic                  flush_o;
    logic [PC_W-1:0]       new_pc_o;
    logic [CNT_W-1:0]      stall_cycles_o;
    logic                  stall_timeout_o;

    modport master (
        output id_reg1_read_en_i, id_reg1_read_addr_i,
        output id_reg2_read_en_i, id_reg2_read_addr_i,
        output ex_is_load_i, ex_write_reg_en_i, ex_write_reg_addr_i,
        output stallreq_ex_i, flush_req_i, flush_pc_i,
        input  stall_o, flush_o, new_pc_o, stall_cycles_o, stall_timeout_o
    );

    modport slave (
        input  id_reg1_read_en_i, id_reg1_read_addr_i,
        input  id_reg2_read_en_i, id_reg2_read_addr_i,
        input  ex_is_load_i, ex_write_reg_en_i, ex_write_reg_addr_i,
        input  stallreq_ex_i, flush_req_i, flush_pc_i,
        output stall_o, flush_o, new_pc_o, stall_cycles_o, stall_timeout_o
    );

endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard detector: the load in EX produces a register that decode
// wants to read this cycle. Purely combinational so forwarding logic can
// reuse it.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic                  reg1_en_i,
    input  logic [REG_ADDR_W-1:0] reg1_addr_i,
    input  logic                  reg2_en_i,
    input  logic [REG_ADDR_W-1:0] reg2_addr_i,
    input  logic                  ex_is_load_i,
    input  logic                  ex_wen_i,
    input  logic [REG_ADDR_W-1:0] ex_waddr_i,
    output logic                  lu_o
);

    logic ex_load_wr;

    // $0 is hardwired to zero, so a load targeting it never blocks decode.
    assign ex_load_wr = ex_is_load_i & ex_wen_i & (ex_waddr_i != '0);

    assign lu_o = ex_load_wr &
                  ((reg1_en_i & (reg1_addr_i == ex_waddr_i)) |
                   (reg2_en_i & (reg2_addr_i == ex_waddr_i)));

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline. Produces the
// per-stage hold vector, registered flush with redirect PC, a saturating
// stall-cycle counter and a sticky watchdog for long EX stalls.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int MAX_EX_STALL = 64,
    parameter int CNT_W        = 32
) (
    input  logic clk,
    input  logic rst,
    pipe_ctrl_if.slave bus
);

    localparam int             WD_W    = $clog2(MAX_EX_STALL + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(MAX_EX_STALL);
    localparam logic [3:0]     FL_LAST = 4'(FLUSH_CYCLES);

    state_e           state_q;
    logic             flush_q;
    logic [PC_W-1:0]  new_pc_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             timeout_q;
    logic [3:0]       flush_cnt_q;
    logic [WD_W-1:0]  wd_q;
    logic             lu;
    stall_t           stall_vec;

    hazard_detect u_hazard (
        .reg1_en_i   (bus.id_reg1_read_en_i),
        .reg1_addr_i (bus.id_reg1_read_addr_i),
        .reg2_en_i   (bus.id_reg2_read_en_i),
        .reg2_addr_i (bus.id_reg2_read_addr_i),
        .ex_is_load_i(bus.ex_is_load_i),
        .ex_wen_i    (bus.ex_write_reg_en_i),
        .ex_waddr_i  (bus.ex_write_reg_addr_i),
        .lu_o        (lu)
    );

    // Hold vector: flush beats EX busy beats load-use; nothing held in FLUSH or reset.
    always_comb begin
        // NOTE: default assigned first so no path through the block leaves it unassigned (no latch).
        stall_vec = STALL_NONE;
        if (rst && (state_q != FLUSH) && !bus.flush_req_i) begin
            if (bus.stallreq_ex_i) begin
                stall_vec = STALL_EX;
            end else if (lu) begin
                stall_vec = STALL_LU;
            end
        end
    end

    // Controller FSM with all registered outputs, counters and watchdog.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            flush_q     <= 1'b0;
            new_pc_q    <= '0;
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
            flush_cnt_q <= '0;
            wd_q        <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values regardless of statement order.
            if ((stall_vec != STALL_NONE) && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            unique case (state_q)
                RUN, EXWAIT: begin
                    if (bus.flush_req_i) begin
                        // Any EX op in flight is abandoned by the redirect.
                        state_q     <= FLUSH;
                        flush_q     <= 1'b1;
                        new_pc_q    <= bus.flush_pc_i;
                        flush_cnt_q <= 4'd1;
                        wd_q        <= '0;
                    end else if (bus.stallreq_ex_i) begin
                        state_q <= EXWAIT;
                        if (wd_q != WD_MAX) begin
                            wd_q <= wd_q + WD_W'(1);
                            if (wd_q == WD_MAX - WD_W'(1)) begin
                                timeout_q <= 1'b1;
                            end
                        end
                    end else begin
                        state_q <= RUN;
                        wd_q    <= '0;
                    end
                end
                FLUSH: begin
                    if (bus.flush_req_i) begin
                        // A fresh redirect restarts the flush window.
                        new_pc_q    <= bus.flush_pc_i;
                        flush_cnt_q <= 4'd1;
                    end else if (flush_cnt_q == FL_LAST) begin
                        state_q     <= RUN;
                        flush_q     <= 1'b0;
                        flush_cnt_q <= '0;
                    end else begin
                        flush_cnt_q <= flush_cnt_q + 4'd1;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign bus.stall_o         = stall_vec;
    assign bus.flush_o         = flush_q;
    assign bus.new_pc_o        = new_pc_q;
    assign bus.stall_cycles_o  = stall_cnt_q;
    assign bus.stall_timeout_o = timeout_q;

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Detects load-use hazards against the operands the decode stage is reading.
- Holds the front of the pipeline while EX runs multicycle ops.
- Sequences registered flushes with a redirect PC.
- Keeps a stall-cycle counter and a sticky EX-stall watchdog flag.

Parameters:
- FLUSH_CYCLES, 1: cycles flush stays asserted per accepted request (1..15).
- MAX_EX_STALL, 64: consecutive EX-busy cycles before stall_timeout sets.
- CNT_W, 32: width of the stall_cycles counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- id_reg1_read_en_i  in  1  decode reads operand 1 from the register file.
- id_reg1_read_addr_i  in  5  decode operand-1 register address.
- id_reg2_read_en_i  in  1  decode reads operand 2 from the register file.
- id_reg2_read_addr_i  in  5  decode operand-2 register address.
- ex_is_load_i  in  1  the instruction currently in EX is a load.
- ex_write_reg_en_i  in  1  the EX instruction writes a register.
- ex_write_reg_addr_i  in  5  destination register of the EX instruction.
- stallreq_ex_i  in  1  EX is busy with a multicycle op.
- flush_req_i  in  1  exception or redirect request.
- flush_pc_i  in  32  redirect target; sampled with flush_req_i.
- stall_o  out  6  hold vector: bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb.
- flush_o  out  1  clear all pipeline registers.
- new_pc_o  out  32  redirect PC, valid while flush_o=1.
- stall_cycles_o  out  CNT_W  count of cycles with stall_o != 0.
- stall_timeout_o  out  1  sticky watchdog flag.

Behaviour:
- Reset (rst=0, async): state=RUN, flush_o=0, new_pc_o=0, stall_cycles_o=0, stall_timeout_o=0, flush and watchdog counters=0. stall_o=0 while in reset.
- States are RUN, EXWAIT and FLUSH. stall_o is combinational from state and inputs; every other output is registered.
- Load-use hazard (lu), combinational:
  - ex_is_load_i & ex_write_reg_en_i & ex_write_reg_addr_i != 0
  - and (id_reg1_read_en_i & addr1 == ex addr) or (id_reg2_read_en_i & addr2 == ex addr).
  - Register $0 never causes a hazard.
- Priority within any cycle: flush_req_i > stallreq_ex_i > lu.
- RUN:
  - flush_req_i: stall_o=000000; capture flush_pc_i into new_pc_o; go to FLUSH.
  - else stallreq_ex_i: stall_o=001111; go to EXWAIT.
  - else lu: stall_o=000111, inserting one bubble into EX; stay in RUN. lu clears the next cycle once the load has moved to MEM.
  - else stall_o=000000.
- EXWAIT:
  - stall_o=001111 while stallreq_ex_i=1; the watchdog increments each cycle.
  - Watchdog reaching MAX_EX_STALL sets stall_timeout_o. The flag is cleared only by reset; the counter saturates.
  - stallreq_ex_i=0: stall_o is evaluated as in RUN (lu may apply); go to RUN; watchdog cleared.
  - flush_req_i: the EX op is abandoned; handled exactly as in RUN; watchdog cleared.
- FLUSH:
  - flush_o=1 for exactly FLUSH_CYCLES cycles starting the cycle after the request; stall_o=000000.
  - Then flush_o=0 and the state returns to RUN; new_pc_o keeps its last value.
  - A new flush_req_i while in FLUSH recaptures flush_pc_i and restarts the count.
  - stallreq_ex_i and lu are ignored in FLUSH.
- stall_cycles_o increments on every edge where stall_o != 0 and saturates at all-ones.
- Reset asserted mid-flush or mid-EXWAIT aborts immediately to reset values.

Decomposition:
- Shared package pipe_pkg holds:
  - the stall bit indices STALL_PC..STALL_WB;
  - vector constants STALL_NONE=6'b000000, STALL_LU=6'b000111, STALL_EX=6'b001111;
  - the state typedef {RUN, EXWAIT, FLUSH};
  - the width constants REG_ADDR_W=5 and PC_W=32.
- One sub-module: hazard_detect, the purely combinational lu computation. It is reusable by later forwarding logic.

Test Plan:
1. Load-use: EX=lw to $8 (is_load=1, wen=1, addr=8); ID reads $8 on port 2 -> stall_o=000111 for exactly 1 cycle; stall_cycles_o increments 0->1.
2. Register $0 and disabled port: EX load to $0 with ID reading $0, and separately ID addr1=8 with en1=0 -> stall_o=000000 in both cases.
3. Multicycle EX: stallreq_ex_i high for 10 cycles -> stall_o=001111 for 10 cycles; return to RUN; stall_timeout_o=0. With MAX_EX_STALL=4 held for 6 cycles -> stall_timeout_o=1 and it stays 1 after release.
4. Flush priority: flush_req_i, stallreq_ex_i and lu all high together, flush_pc_i=0x00000140 -> stall_o=000000 that cycle; next cycle flush_o=1 and new_pc_o=0x00000140 for FLUSH_CYCLES cycles, then flush_o=0.
5. Back-to-back flush: with FLUSH_CYCLES=3, a second request (pc=0x00000200) arrives in the 2nd flush cycle -> new_pc_o=0x00000200 and flush_o stays high 3 more cycles.
6. Async reset mid-EXWAIT: drive rst=0 between clock edges -> all outputs return to reset values immediately, without waiting for a clock edge.
